// File: rtl/clb_config_loader.sv
// clb_config_loader
// Serial configuration loader for an array of CLBs. It hunts for a sync
// byte, reads an 8-bit frame count N, then reads N frames of FRAME_W bits.
// Each frame is followed by one even-parity bit. Every good frame is
// written to the configuration store with a one-cycle strobe.
//
// Ports
//   k         : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   start     : begin a load (honoured in IDLE, DONE, ERROR)
//   din       : serial data, MSB first
//   dvalid    : din qualifier; nothing advances while low
//   cfg_we    : one-cycle write strobe
//   cfg_addr  : CLB index for cfg_we (held between writes)
//   cfg_data  : frame contents for cfg_we (held between writes)
//   busy      : high in SYNC, COUNT, FRAME
//   done      : load finished, held until start/rst
//   err       : load aborted, held until start/rst
//
// state | meaning
// IDLE  | waiting for start after reset
// SYNC  | shifting bits until the sync word is seen
// COUNT | collecting the 8-bit frame count
// FRAME | collecting frame bits plus parity, writing good frames
// DONE  | all N frames written
// ERROR | bad count or parity, load abandoned
module clb_config_loader #(
   parameter int          NUM_CLB   = 16,
   parameter int          FRAME_W   = 37,
   parameter logic [7:0]  SYNC_WORD = 8'hB2,
   localparam int         AW        = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1
) (
   input  logic               k,
   input  logic               rst,
   input  logic               start,
   input  logic               din,
   input  logic               dvalid,
   output logic               cfg_we,
   output logic [AW-1:0]      cfg_addr,
   output logic [FRAME_W-1:0] cfg_data,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int BCW = $clog2(FRAME_W + 2);

   typedef enum logic [2:0] {
      IDLE, SYNC, COUNT, FRAME, DONE, ERROR
   } state_t;

   state_t             state;
   logic [7:0]         sync_sr;
   logic [7:0]         n_frames;
   logic [7:0]         idx;
   logic [BCW-1:0]     bit_cnt;
   logic [FRAME_W-1:0] frame_sr;
   logic               par;

   logic [7:0]         sync_nx;
   logic [7:0]         cnt_nx;
   logic [7:0]         idx_nx;

   assign sync_nx = {sync_sr[6:0], din};
   assign cnt_nx  = {n_frames[6:0], din};
   assign idx_nx  = idx + 8'd1;

   always_ff @(posedge k) begin
      if (rst) begin
         state    <= IDLE;
         sync_sr  <= '0;
         n_frames <= '0;
         idx      <= '0;
         bit_cnt  <= '0;
         frame_sr <= '0;
         par      <= 1'b0;
         cfg_we   <= 1'b0;
         cfg_addr <= '0;
         cfg_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         cfg_we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state    <= SYNC;
                  sync_sr  <= '0;
                  n_frames <= '0;
                  idx      <= '0;
                  bit_cnt  <= '0;
                  par      <= 1'b0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            SYNC: begin
               if (dvalid) begin
                  sync_sr <= sync_nx;
                  if (sync_nx == SYNC_WORD) begin
                     state   <= COUNT;
                     bit_cnt <= '0;
                  end
               end
            end
            COUNT: begin
               if (dvalid) begin
                  n_frames <= cnt_nx;
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == BCW'(7)) begin
                     bit_cnt <= '0;
                     if (cnt_nx == 8'd0 || cnt_nx > 8'(NUM_CLB)) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                     end else begin
                        state <= FRAME;
                        idx   <= '0;
                        par   <= 1'b0;
                     end
                  end
               end
            end
            FRAME: begin
               if (dvalid) begin
                  if (bit_cnt < BCW'(FRAME_W)) begin
                     frame_sr <= {frame_sr[FRAME_W-2:0], din};
                     par      <= par ^ din;
                     bit_cnt  <= bit_cnt + 1'b1;
                  end else if (par ^ din) begin
                     // odd parity over data+parity: drop the frame entirely
                     state <= ERROR;
                     busy  <= 1'b0;
                     err   <= 1'b1;
                  end else begin
                     cfg_we   <= 1'b1;
                     cfg_addr <= idx[AW-1:0];
                     cfg_data <= frame_sr;
                     idx      <= idx_nx;
                     bit_cnt  <= '0;
                     par      <= 1'b0;
                     if (idx_nx == n_frames) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clb_config_loader.sv
module tb_clb_config_loader;

   localparam int NUM_CLB = 4;
   localparam int FRAME_W = 37;
   localparam int AW      = 2;

   logic               k = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               din = 1'b0;
   logic               dvalid = 1'b0;
   logic               cfg_we;
   logic [AW-1:0]      cfg_addr;
   logic [FRAME_W-1:0] cfg_data;
   logic               busy;
   logic               done;
   logic               err;

   clb_config_loader #(.NUM_CLB(NUM_CLB), .FRAME_W(FRAME_W), .SYNC_WORD(8'hB2)) dut (
      .k(k), .rst(rst), .start(start), .din(din), .dvalid(dvalid),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 k = ~k;

   int errors = 0;
   int checks = 0;
   int n_writes = 0;

   typedef logic [AW+FRAME_W-1:0] wr_t;
   wr_t exp_q[$];
   bit  stream[$];

   typedef struct {
      int         junk;
      logic [7:0] cnt;
      int         nfr;
      int         bad;
      bit         gaps;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [FRAME_W-1:0] frame_of(input int i);
      case (i)
         0:       return 37'h1_0000_0116;
         1:       return {FRAME_W{1'b1}};
         2:       return 37'h0A_BCDE_F012;
         default: return 37'h15_5AA5_3C3C;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // write monitor: every strobe must match the head of the scoreboard
   always @(negedge k) begin
      if (cfg_we) begin
         n_writes++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", cfg_addr, cfg_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({cfg_addr, cfg_data} !== e) begin
               errors++;
               $display("FAIL write_data: got addr=%0h data=%0h expected addr=%0h data=%0h",
                        cfg_addr, cfg_data, e[AW+FRAME_W-1:FRAME_W], e[FRAME_W-1:0]);
            end
         end
      end
      if (done && err) begin
         checks++;
         errors++;
         $display("FAIL done_err_both: done=%b err=%b, required not both", done, err);
      end
   end

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
   endtask

   task automatic push_frame(input int i, input bit bad_par);
      logic [FRAME_W-1:0] d;
      d = frame_of(i);
      for (int j = FRAME_W - 1; j >= 0; j--) stream.push_back(d[j]);
      stream.push_back((^d) ^ bad_par);
   endtask

   // sends up to 'limit' bits of the stream (all if limit<0)
   task automatic send(input bit gaps, input int limit);
      int sent;
      sent = 0;
      while (stream.size() > 0 && (limit < 0 || sent < limit)) begin
         if (gaps) begin
            while ($urandom_range(0, 9) < 3) begin
               dvalid = 1'b0;
               din    = $urandom_range(0, 1);
               @(posedge k); #1;
            end
         end
         din    = stream.pop_front();
         dvalid = 1'b1;
         @(posedge k); #1;
         sent++;
      end
      dvalid = 1'b0;
      din    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge k); #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge k); #1; end
   endtask

   task automatic build(input vec_t v);
      logic [2:0] junk_bits;
      junk_bits = 3'b110;
      stream.delete();
      for (int j = 0; j < v.junk; j++) stream.push_back(junk_bits[2 - (j % 3)]);
      push_byte(8'hB2);
      push_byte(v.cnt);
      for (int f = 0; f < v.nfr; f++) begin
         push_frame(f, f == v.bad);
         if (v.bad < 0 || f < v.bad)
            exp_q.push_back({AW'(f), frame_of(f)});
      end
   endtask

   initial begin
      vecs[0] = '{junk:0, cnt:8'd2, nfr:2, bad:-1, gaps:0, exp_done:1, exp_err:0};
      vecs[1] = '{junk:3, cnt:8'd1, nfr:1, bad:-1, gaps:0, exp_done:1, exp_err:0};
      vecs[2] = '{junk:0, cnt:8'd0, nfr:0, bad:-1, gaps:0, exp_done:0, exp_err:1};
      vecs[3] = '{junk:0, cnt:8'd5, nfr:0, bad:-1, gaps:0, exp_done:0, exp_err:1};
      vecs[4] = '{junk:0, cnt:8'd2, nfr:2, bad:1,  gaps:0, exp_done:0, exp_err:1};
      vecs[5] = '{junk:0, cnt:8'd3, nfr:3, bad:-1, gaps:1, exp_done:1, exp_err:0};
      vecs[6] = '{junk:0, cnt:8'd3, nfr:3, bad:-1, gaps:0, exp_done:1, exp_err:0};
      vecs[7] = '{junk:5, cnt:8'd4, nfr:4, bad:-1, gaps:1, exp_done:1, exp_err:0};

      idle(2);
      chk("reset_outputs", {cfg_we, cfg_addr, cfg_data, busy, done, err}, '0);
      rst = 1'b0;
      idle(2);
      chk("idle_no_busy", {busy, done, err}, 3'b000);

      for (int t = 0; t < 8; t++) begin
         int w0, nexp;
         w0   = n_writes;
         nexp = exp_q.size();
         build(vecs[t]);
         nexp = exp_q.size() - nexp;
         do_start();
         chk($sformatf("v%0d_busy_after_start", t), {busy, done, err}, 3'b100);
         send(vecs[t].gaps, -1);
         idle(3);
         chk($sformatf("v%0d_done", t), done, vecs[t].exp_done);
         chk($sformatf("v%0d_err", t), err, vecs[t].exp_err);
         chk($sformatf("v%0d_busy", t), busy, 1'b0);
         chk($sformatf("v%0d_writes", t), n_writes - w0, nexp);
         chk($sformatf("v%0d_sb_empty", t), exp_q.size(), 0);
         if (vecs[t].exp_done)
            chk($sformatf("v%0d_data_held", t), {cfg_addr, cfg_data},
                {AW'(vecs[t].nfr - 1), frame_of(vecs[t].nfr - 1)});
      end

      // start ignored while busy, and dvalid=0 freezes progress
      begin
         vec_t v;
         v = '{junk:0, cnt:8'd1, nfr:1, bad:-1, gaps:0, exp_done:1, exp_err:0};
         build(v);
         do_start();
         send(0, 20);
         start = 1'b1;
         idle(4);
         start = 1'b0;
         chk("start_ignored_busy", {busy, done, err}, 3'b100);
         send(0, -1);
         idle(2);
         chk("resume_done", {busy, done, err}, 3'b010);
         chk("resume_sb_empty", exp_q.size(), 0);
      end

      // reset at frame1 bit 20: frame0 written, frame1 discarded
      begin
         vec_t v;
         int w0;
         v = '{junk:0, cnt:8'd2, nfr:2, bad:-1, gaps:0, exp_done:1, exp_err:0};
         w0 = n_writes;
         stream.delete();
         push_byte(8'hB2);
         push_byte(8'd2);
         push_frame(0, 0);
         push_frame(1, 0);
         exp_q.push_back({AW'(0), frame_of(0)});
         do_start();
         send(0, 16 + (FRAME_W + 1) + 20);
         rst = 1'b1;
         @(posedge k); #1;
         rst = 1'b0;
         chk("rst_outputs", {cfg_we, cfg_addr, cfg_data, busy, done, err}, '0);
         idle(3);
         chk("rst_one_write", n_writes - w0, 1);
         chk("rst_sb_empty", exp_q.size(), 0);
         chk("rst_idle", {busy, done, err}, 3'b000);
         build(v);
         do_start();
         send(0, -1);
         idle(2);
         chk("reload_done", {busy, done, err}, 3'b010);
         chk("reload_sb_empty", exp_q.size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clb_config_loader.md
CLB_CONFIG_LOADER -- requirements
Module: clb_config_loader

Interface
REQ-001 Parameter NUM_CLB, default 16: number of CLB configuration slots addressable.
REQ-002 Parameter FRAME_W, default 37: configuration bits per CLB frame. The 37 bits are 16 LUT, 2 comboption, 10 mux selects, 6 o2m, 2 DQmux and 1 floporlatch.
REQ-003 Parameter SYNC_WORD, default 8'hB2: preamble marking stream start.
REQ-004 K  input  1: sole clock; all state updates on rising edge.
REQ-005 RST  input  1: synchronous, active-high reset.
REQ-006 START  input  1: begin a load; sampled only in IDLE, DONE and ERROR.
REQ-007 DIN  input  1: serial configuration bit, MSB first.
REQ-008 DVALID  input  1: DIN qualifier; a bit is consumed only on edges where DVALID=1.
REQ-009 CFG_WE  output  1: one-cycle write strobe to the CLB configuration store.
REQ-010 CFG_ADDR  output  clog2(NUM_CLB): target CLB index for CFG_WE.
REQ-011 CFG_DATA  output  FRAME_W: frame contents for CFG_WE.
REQ-012 BUSY  output  1: high in SYNC, COUNT and FRAME.
REQ-013 DONE  output  1: load completed successfully; held.
REQ-014 ERR  output  1: load aborted; held.

Function
REQ-015 The FSM SHALL have states IDLE, SYNC, COUNT, FRAME, DONE and ERROR.
REQ-016 In IDLE, START=1 SHALL move the FSM to SYNC and clear the 8-bit sync shift register.
REQ-017 In SYNC, each valid bit SHALL shift into the sync register. When the register equals SYNC_WORD after a shift, the FSM SHALL go to COUNT; preceding junk bits are ignored.
REQ-018 COUNT SHALL capture 8 valid bits, MSB first, as frame count N.
REQ-019 If N=0 or N>NUM_CLB, the FSM SHALL go to ERROR on the edge consuming the 8th bit; otherwise it SHALL go to FRAME with index=0.
REQ-020 FRAME SHALL capture FRAME_W data bits plus 1 parity bit. Even parity SHALL hold: XOR of all FRAME_W+1 bits = 0.
REQ-021 On a parity mismatch, the FSM SHALL go to ERROR and no CFG_WE SHALL be issued for that frame.
REQ-022 On a parity match, the edge consuming the parity bit SHALL register CFG_WE=1, CFG_ADDR=index and CFG_DATA=frame, visible for exactly the following cycle.
REQ-023 After a good frame, index SHALL increment. If the new index equals N, the FSM SHALL go to DONE; otherwise it SHALL stay in FRAME with the bit counter cleared.
REQ-024 A valid bit arriving in the CFG_WE cycle SHALL be taken as bit 0 of the next frame; no bits are dropped and there are no wait cycles.
REQ-025 DVALID=0 SHALL freeze all counters and shift registers in every state; FSM transitions occur only on consuming edges.
REQ-026 CFG_ADDR and CFG_DATA SHALL hold their last written values while CFG_WE=0.
REQ-027 CFG_WE SHALL never be high outside the cycle after a good parity bit.
REQ-028 DONE=1 and ERR=1 SHALL each hold until START or RST.
REQ-029 START in DONE or ERROR SHALL clear both flags and enter SYNC.
REQ-030 START in SYNC, COUNT or FRAME SHALL be ignored.
REQ-031 DONE and ERR SHALL never be high together.
REQ-032 The bit counter SHALL be wide enough for FRAME_W+1. The index and N comparison SHALL use 8 bits, independent of the CFG_ADDR width.

Reset
REQ-033 RST=1 on a K edge SHALL force IDLE; CFG_WE, CFG_ADDR, CFG_DATA, BUSY, DONE and ERR SHALL all be 0.
REQ-034 RST=1 SHALL clear the sync register, bit counter, index and N; RST has priority over START and DVALID.
REQ-035 RST mid-FRAME SHALL discard the partial frame with no CFG_WE. Frames already written SHALL NOT be retracted.

Verification
REQ-036 Bench: NUM_CLB=4, START, stream B2, 02, frame0=37'h1_0000_0116 with parity, frame1=all-ones with parity, DVALID=1 continuous -> CFG_WE pulses at addr 0 then 1 with exact data, then DONE=1, BUSY=0, ERR=0.
REQ-037 Bench: bits 1,1,0 then B2 then count 01 and a valid frame -> sync found after the junk bits; one CFG_WE at addr 0; DONE=1.
REQ-038 Bench: count 00, and separately count 05 with NUM_CLB=4 -> ERR=1 after the 8th count bit; no CFG_WE.
REQ-039 Bench: frame1 parity bit flipped -> CFG_WE for addr 0 only; ERR=1; then START with a good stream -> ERR clears and DONE=1.
REQ-040 Bench: random DVALID gaps (about 30% low) across a 3-frame load -> CFG_WE data and addresses identical to the gap-free run.
REQ-041 Bench: RST pulsed at frame1 bit 20 -> all outputs 0 the next cycle, IDLE, no CFG_WE for frame1; a new START reloads correctly.
